// File: rtl/sprite_scene_loader.sv
// sprite_scene_loader: framed byte-stream loader that atomically commits per-sprite init records
//   clk_162/rst          : clock, async active-high reset
//   in_data/in_valid     : byte stream in, in_ready back-pressure (low only in the commit cycle)
//   init_locations/velos : [SPRITES][DIMENSIONS][WIDTH] committed vectors
//   masses/radii         : [SPRITES][WIDTH/2] and [SPRITES][7] committed scalars
//   data_ready           : one-cycle commit strobe, frame_err sticky until next commit
module sprite_scene_loader #(
  parameter int SPRITES    = 9,
  parameter int WIDTH      = 32,
  parameter int DIMENSIONS = 2
) (
  input  logic                                           clk_162,
  input  logic                                           rst,
  input  logic [7:0]                                     in_data,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  output logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0]  init_locations,
  output logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0]  init_velos,
  output logic [SPRITES-1:0][WIDTH/2-1:0]                masses,
  output logic [SPRITES-1:0][6:0]                        radii,
  output logic                                           data_ready,
  output logic                                           frame_err
);
  localparam int R     = DIMENSIONS*WIDTH/4 + WIDTH/16 + 1;
  localparam int TOTAL = SPRITES*R;
  localparam int CW    = $clog2(TOTAL+1);
  localparam int NF    = 2*DIMENSIONS + 2;
  localparam int FW    = $clog2(NF);
  localparam int SW    = SPRITES > 1 ? $clog2(SPRITES) : 1;
  localparam int DW    = DIMENSIONS > 1 ? $clog2(DIMENSIONS) : 1;
  localparam int BW    = WIDTH > 8 ? $clog2(WIDTH/8) : 1;
  localparam int MW    = WIDTH/2;
  localparam logic [CW-1:0] LAST   = CW'(TOTAL-1);
  localparam logic [FW-1:0] F_VELO = FW'(DIMENSIONS);
  localparam logic [FW-1:0] F_MASS = FW'(2*DIMENSIONS);
  localparam logic [FW-1:0] F_RAD  = FW'(2*DIMENSIONS+1);
  localparam logic [BW-1:0] B_VEC  = BW'(WIDTH/8-1);
  localparam logic [BW-1:0] B_MASS = BW'(WIDTH/16-1);
  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK, COMMIT} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [7:0]    sum;
  logic [SW-1:0] spr;
  logic [FW-1:0] fld;
  logic [BW-1:0] bidx, flen_m1;
  logic [DW-1:0] dim;
  logic          acc, fld_last;
  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] sh_loc, sh_velo;
  logic [SPRITES-1:0][MW-1:0]                    sh_mass;
  logic [SPRITES-1:0][6:0]                       sh_rad;

  always_comb begin
    in_ready  = state != COMMIT;
    acc       = in_valid && in_ready;
    dim       = fld < F_VELO ? DW'(fld) : DW'(fld - F_VELO);
    flen_m1   = fld < F_MASS ? B_VEC : fld == F_MASS ? B_MASS : '0;
    fld_last  = bidx == flen_m1;
    state_nxt = state == COMMIT ? HUNT :
                !acc             ? state :
                state == HUNT    ? (in_data == 8'hA5 ? PAYLOAD : HUNT) :
                state == PAYLOAD ? (cnt == LAST ? CHECK : PAYLOAD) :
                                   (in_data == sum ? COMMIT : HUNT);
  end

  always_ff @(posedge clk_162 or posedge rst)
    if (rst) state <= HUNT;
    else     state <= state_nxt;

  always_ff @(posedge clk_162 or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      sum            <= '0;
      spr            <= '0;
      fld            <= '0;
      bidx           <= '0;
      sh_loc         <= '0;
      sh_velo        <= '0;
      sh_mass        <= '0;
      sh_rad         <= '0;
      init_locations <= '0;
      init_velos     <= '0;
      masses         <= '0;
      radii          <= '0;
      data_ready     <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      data_ready <= state == COMMIT;
      if (state == COMMIT) begin
        init_locations <= sh_loc;
        init_velos     <= sh_velo;
        masses         <= sh_mass;
        radii          <= sh_rad;
        frame_err      <= 1'b0;
      end
      if (acc && state == HUNT && in_data == 8'hA5) begin
        cnt  <= '0;
        sum  <= '0;
        spr  <= '0;
        fld  <= '0;
        bidx <= '0;
      end
      if (acc && state == PAYLOAD) begin
        cnt <= cnt + 1'b1;
        sum <= sum ^ in_data;
        // fields arrive MSB byte first, so each byte shifts in from the bottom
        if (fld < F_VELO)       sh_loc[spr][dim]  <= WIDTH'({sh_loc[spr][dim], in_data});
        else if (fld < F_MASS)  sh_velo[spr][dim] <= WIDTH'({sh_velo[spr][dim], in_data});
        else if (fld == F_MASS) sh_mass[spr]      <= MW'({sh_mass[spr], in_data});
        else                    sh_rad[spr]       <= in_data[6:0];
        bidx <= fld_last ? '0 : bidx + 1'b1;
        if (fld_last) begin
          fld <= fld == F_RAD ? '0 : fld + 1'b1;
          if (fld == F_RAD) spr <= spr + 1'b1;
        end
      end
      if (acc && state == CHECK && in_data != sum) frame_err <= 1'b1;
    end
  end
endmodule
